// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types for the cipher-core blocks.
// Sparse one-hot FSM encoding keeps single bit flips detectable as illegal states.
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    typedef enum logic [2:0] {
        MIX_IDLE = 3'b001,
        MIX_BUSY = 3'b010,
        MIX_DONE = 3'b100
    } mix_iter_state_e;

endpackage

// File: rtl/aes_mix_single_column.sv
// aes_mix_single_column: combinational MixColumns / InvMixColumns on one column.
// An op that is neither CIPH_FWD nor CIPH_INV yields an all-zero column.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e          op_i,
    input  logic [3:0][7:0]   data_i,
    output logic [3:0][7:0]   data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & a2) ^ ({8{c[2]}} & a4) ^ ({8{c[3]}} & a8);
    endfunction

    logic [3:0][3:0] coef;
    logic            op_ok;

    // Row r sums coef[j] * data_i[r+j]: forward {2,3,1,1}, inverse {e,b,d,9}.
    always_comb begin
        op_ok  = (op_i == CIPH_FWD) || (op_i == CIPH_INV);
        coef   = (op_i == CIPH_INV) ? {4'h9, 4'hd, 4'hb, 4'he} : {4'h1, 4'h1, 4'h3, 4'h2};
        data_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                data_o[r] = data_o[r] ^ gmul(data_i[2'(r + j)], coef[j]);
            end
            data_o[r] = op_ok ? data_o[r] : 8'h00;
        end
    end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// aes_mix_columns_iter: handshaked MixColumns engine sharing NumColUnits column
// units over the four columns of the state, one group of columns per pass.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter  int NumColUnits = 1,
    localparam int NumPasses   = 4 / NumColUnits
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  ciph_op_e              op_i,
    input  logic [3:0][3:0][7:0]  state_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  state_o,
    output logic                  op_err_o
);

    localparam int CntW = (NumPasses > 1) ? $clog2(NumPasses) : 1;

    if (!(NumColUnits == 1 || NumColUnits == 2 || NumColUnits == 4)) begin : g_bad_units
        $error("NumColUnits must be 1, 2 or 4");
    end

    mix_iter_state_e                      fsm_q, fsm_d;
    ciph_op_e                             op_q, op_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [3:0][3:0][7:0]                 state_q, state_d;
    logic [NumColUnits-1:0][3:0][7:0]     col_in, col_out;
    logic                                 last_pass;

    always_comb begin
        col_in = '0;
        for (int k = 0; k < NumColUnits; k++) begin
            col_in[k] = state_q[2'(int'(cnt_q) * NumColUnits + k)];
        end
    end

    for (genvar k = 0; k < NumColUnits; k++) begin : g_col
        aes_mix_single_column u_col (
            .op_i   (op_q),
            .data_i (col_in[k]),
            .data_o (col_out[k])
        );
    end

    assign last_pass = (cnt_q == CntW'(NumPasses - 1));

    always_comb begin
        fsm_d   = fsm_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            MIX_IDLE: begin
                if (in_valid_i) begin
                    state_d = state_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    fsm_d   = MIX_BUSY;
                end
            end
            MIX_BUSY: begin
                for (int c = 0; c < 4; c++) begin
                    if (c / NumColUnits == int'(cnt_q)) state_d[c] = col_out[c % NumColUnits];
                end
                cnt_d = last_pass ? '0 : cnt_q + 1'b1;
                fsm_d = last_pass ? MIX_DONE : MIX_BUSY;
            end
            MIX_DONE: fsm_d = out_ready_i ? MIX_IDLE : MIX_DONE;
            default:  fsm_d = MIX_IDLE;
        endcase
        if (clear_i) begin
            fsm_d   = MIX_IDLE;
            op_d    = ciph_op_e'(2'b00);
            cnt_d   = '0;
            state_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= MIX_IDLE;
            op_q    <= ciph_op_e'(2'b00);
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign in_ready_o  = (fsm_q == MIX_IDLE);
    assign out_valid_o = (fsm_q == MIX_DONE);
    assign state_o     = out_valid_o ? state_q : '0;
    assign op_err_o    = out_valid_o && !(op_q == CIPH_FWD || op_q == CIPH_INV);

    a_valid_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o |-> fsm_q == MIX_DONE);
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i && !clear_i |=> $stable(state_o));

endmodule

// File: doc/aes_mix_columns_iter.md
# aes_mix_columns_iter

Iterative, handshaked AES MixColumns / InvMixColumns engine for a full 128-bit state. It time-multiplexes `NumColUnits` instances of `aes_mix_single_column` over the four state columns, so area and latency can be traded at elaboration time. It sits between ShiftRows and AddRoundKey in area-optimised cipher-core variants. It adds a valid/ready flow, a synchronous clear and an invalid-operation flag on top of the combinational column primitive.

## Interface
- `NumColUnits`, default 1: number of parallel column units; legal values 1, 2, 4.
- `NumPasses`, derived as 4/`NumColUnits`, not overridable: cycles spent in BUSY.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `clear_i`  in  1  synchronous abort and wipe.
- `in_valid_i`  in  1  input state valid.
- `in_ready_o`  out  1  engine can accept a state.
- `op_i`  in  `ciph_op_e`  CIPH_FWD or CIPH_INV; sampled on input handshake.
- `state_i`  in  [3:0][3:0][7:0]  input state, indexed [col][row].
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `state_o`  out  [3:0][3:0][7:0]  result state, indexed [col][row].
- `op_err_o`  out  1  sampled op was neither CIPH_FWD nor CIPH_INV; qualified by `out_valid_o`.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. The encoding is sparse and lives in the package.
- **IDLE**
  - `in_ready_o`=1.
  - When `in_valid_i` is high, the block latches `state_i` into the state register and `op_i` into the op register, clears the pass counter, and moves to BUSY.
- **BUSY**
  - `in_ready_o`=0.
  - On pass p (0..`NumPasses`-1), unit k processes column p·`NumColUnits`+k. The unit output is written back into that column of the state register.
  - Pass p=`NumPasses`-1 moves the FSM to DONE.
- **DONE**
  - `out_valid_o`=1 and `state_o` = state register.
  - `state_o` and `op_err_o` are held stable until `out_ready_i` is seen.
  - On the output handshake, the block returns to IDLE. There is no same-cycle accept of a new input.
- **Invalid op:** the column units are fed the latched op. For an invalid op the result is forced to all-zero and `op_err_o`=1 in DONE.
- **`clear_i`:** from any state, the next cycle is IDLE. The state register, op register and pass counter are zeroed. `clear_i` has priority over both handshakes.
- **Reset values:** FSM in IDLE, `in_ready_o`=1, `out_valid_o`=0, `state_o`=0, `op_err_o`=0, pass counter 0.
- **Reset asserted mid-BUSY or mid-DONE:** the result is discarded and the block comes out of reset in IDLE with zero data.
- `in_valid_i` is ignored outside IDLE.
- An `out_ready_i` held high while not in DONE has no effect.

## Timing
- Input handshake at rising edge t gives BUSY in cycles t+1..t+`NumPasses`.
- `out_valid_o` rises in cycle t+`NumPasses`+1: latency is 5 cycles for 1 unit, 3 for 2 units, 2 for 4 units.
- If `out_ready_i` is high in the first DONE cycle, `in_ready_o` is high in the following cycle. Sustained throughput is one state per `NumPasses`+2 cycles.
- The pass-counter width is max(1, $clog2(`NumPasses`)). With `NumColUnits`=4 the counter is unused and must tie off cleanly.
- All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.
- All column arithmetic is GF(2^8) modulo x^8+x^4+x^3+x+1 and is done in the sub-module only.

## Structure
- **Package `aes_pkg`:** add `mix_iter_state_e` with a sparse encoding; reuse `ciph_op_e`, `CIPH_FWD` and `CIPH_INV`.
- **Elaboration-time assertion:** `NumColUnits` is in {1,2,4}.
- **Sub-module:** `NumColUnits` instances of `aes_mix_single_column`. Column selection is a mux on the pass counter; write-back is a per-column enable.
- **Assertions**
  - `out_valid_o` implies FSM==DONE.
  - `state_o` is stable while `out_valid_o` && !`out_ready_i`.

## Test plan
- **FIPS-197 forward vectors, every `NumColUnits`:** FWD with columns {db,13,53,45}, {f2,0a,22,5c}, {c6,c6,c6,c6}, {d4,d4,d4,d5}. Required: {8e,4d,a1,bc}, {9f,dc,58,9d}, {c6,c6,c6,c6}, {d5,d5,d7,d6}, and `out_valid_o` exactly `NumPasses`+1 cycles after the input handshake.
- **Inverse vectors:** INV with the four expected outputs above as input. Required: the original four columns back, with `op_err_o`=0.
- **Invalid op:** `op_i`=2'b11. Required: `state_o` all-zero and `op_err_o`=1 in DONE.
- **Output backpressure:** hold `out_ready_i`=0 for 10 cycles in DONE. Required: `state_o` and `out_valid_o` stable, `in_ready_o`=0, and `in_valid_i` pulses ignored.
- **Clear during BUSY:** assert `clear_i` in pass 1 with `NumColUnits`=1. Required: next cycle IDLE, state register 0, `out_valid_o` never rises. A following FIPS vector then produces the correct result.
- **Reset during DONE:** pull `rst_ni` low in DONE. Required: outputs go to reset values asynchronously, and after release `in_ready_o`=1 with `state_o`=0.
